// File: rtl/fnd_pkg.sv
// Shared definitions for the popcount / FND display slice.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   SEG_0..SEG_9, SEG_BLANK  active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   state_t                  counter FSM encoding (IDLE, COUNT)
//   bin2bcd()                14-bit binary to 4-digit BCD (double dabble)
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // 14 input bits cover 0..9999. Each step corrects any BCD nibble >= 5
  // by +3 before the shift, so it carries correctly into the next decade.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int k = 0; k < 4; k++) begin
        if (bcd[4*k +: 4] >= 4'd5) begin
          bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage

// File: rtl/fnd_digit_dec.sv
// BCD digit to active-low 7-segment decoder with a blank override.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   bcd    in  4  BCD digit (10..15 decode to blank)
//   blank  in  1  force all segments off
//   seg    out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module fnd_digit_dec
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/popcount_fnd_scan.sv
// Bit-serial ones counter with start/busy/done, result shown on a scanned 4-digit FND.
// Latency: done pulses WIDTH cycles after the accepted start edge; display follows count one cycle later.
// Backpressure: none; start is sampled only in IDLE, start while busy is dropped (no queueing).
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous reset, active-low
//   start   in   1      request a count of d (sampled only in IDLE)
//   d       in   WIDTH  vector to count, captured on the accepted start edge
//   busy    out  1      high while counting
//   done    out  1      one-cycle pulse when count updates
//   count   out  CW     last completed ones count
//   fnd     out  7      segments {g,f,e,d,c,b,a}, active-low
//   fndsel  out  4      digit enables, active-low, [0]=ones .. [3]=thousands
//
// Build option: define POPCNT_LZ_BLANK_EN to blank leading-zero digits
// (the ones digit is always shown).
module popcount_fnd_scan
  import fnd_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int SCAN_DIV = 50000,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [6:0]       fnd,
  output logic [3:0]       fndsel
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ---------------- counter FSM ----------------
  state_t           state, state_nx;
  logic             load, step, last;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    bitcnt;
  logic [CW-1:0]    acc_nx;

  assign last   = (bitcnt == CW'(WIDTH - 1));
  assign acc_nx = acc + CW'(shift[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = COUNT;
        end
      end
      COUNT: begin
        step = 1'b1;
        if (last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift  <= '0;
      acc    <= '0;
      bitcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shift  <= d;
        acc    <= '0;
        bitcnt <= '0;
        busy   <= 1'b1;
      end else if (step) begin
        shift  <= shift >> 1;
        acc    <= acc_nx;
        bitcnt <= bitcnt + CW'(1);
        if (last) begin
          // Fold in the final bit directly so count is valid with done.
          count <= acc_nx;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

  // ---------------- display ----------------
  logic [15:0]   bcd;
  logic [SW-1:0] scan_cnt;
  logic          scan_tc;
  logic [1:0]    idx, idx_nx;
  logic [3:0]    dig;
  logic          blank;
  logic [6:0]    seg_nx;

  assign bcd     = bin2bcd(14'(count));
  assign scan_tc = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_nx  = scan_tc ? idx + 2'd1 : idx;

  // Decode the digit that will be selected after this edge, so fnd and
  // fndsel register together and never disagree.
  always_comb begin
    dig = bcd[3:0];
    case (idx_nx)
      2'd0: dig = bcd[3:0];
      2'd1: dig = bcd[7:4];
      2'd2: dig = bcd[11:8];
      2'd3: dig = bcd[15:12];
      default: dig = bcd[3:0];
    endcase
  end

`ifdef POPCNT_LZ_BLANK_EN
  logic z3, z2, z1;
  // A digit is a leading zero when it and every higher digit are zero.
  assign z3 = (bcd[15:12] == 4'd0);
  assign z2 = z3 && (bcd[11:8] == 4'd0);
  assign z1 = z2 && (bcd[7:4] == 4'd0);

  always_comb begin
    blank = 1'b0;
    case (idx_nx)
      2'd1: blank = z1;
      2'd2: blank = z2;
      2'd3: blank = z3;
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  fnd_digit_dec u_dec (
    .bcd   (dig),
    .blank (blank),
    .seg   (seg_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      fndsel   <= 4'b1110;
      fnd      <= SEG_0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + SW'(1);
      idx      <= idx_nx;
      fndsel   <= ~(4'b0001 << idx_nx);
      fnd      <= seg_nx;
    end
  end

endmodule
